// File: rtl/pipe_pkg.sv
// Types and constants shared between the reorder buffer and the retire stage.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [DATA_W-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;
  localparam logic [REG_AW-1:0] REG_ZERO           = 5'd0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } retire_state_t;

endpackage

// File: rtl/retire_unit.sv
// In-order commit stage: turns the ROB head into an RF write, a store, or a precise exception.
// Optional macro RETIRE_COUNT_EN adds a free-running retired-entry counter output.
module retire_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          DW         = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              head_valid,
  input  logic [DW-1:0]     head_val,
  input  logic [REG_AW-1:0] head_rd,
  input  logic              head_store,
  input  logic [DW-1:0]     head_addr,
  input  logic              head_ex,
  input  logic [DW-1:0]     head_pc,
  output logic              head_pop,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              st_req,
  output logic [DW-1:0]     st_addr,
  output logic [DW-1:0]     st_data,
  input  logic              st_ack,
  output logic              flush,
  output logic [DW-1:0]     redirect_pc,
  output logic [DW-1:0]     epc
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  retire_state_t state_reg;

  assign redirect_pc = EXC_VECTOR[DW-1:0];

  // A store is popped only once memory has accepted it, so the entry is never lost.
  always_comb begin
    head_pop = 1'b0;
    if (rst_n && !stall) begin
      case (state_reg)
        RUN:     head_pop = head_valid && (head_ex || !head_store);
        ST_WAIT: head_pop = st_ack;
        default: head_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      st_req    <= 1'b0;
      st_addr   <= '0;
      st_data   <= '0;
      flush     <= 1'b0;
      epc       <= '0;
    end else begin
      rf_we <= 1'b0;
      flush <= 1'b0;
      if (!stall) begin
        case (state_reg)
          RUN: begin
            if (head_valid) begin
              if (head_ex) begin
                flush     <= 1'b1;
                epc       <= head_pc;
                state_reg <= FLUSH;
              end else if (head_store) begin
                st_req    <= 1'b1;
                st_addr   <= head_addr;
                st_data   <= head_val;
                state_reg <= ST_WAIT;
              end else begin
                rf_we    <= (head_rd != REG_ZERO);
                rf_waddr <= head_rd;
                rf_wdata <= head_val;
              end
            end
          end
          ST_WAIT: begin
            if (st_ack) begin
              st_req    <= 1'b0;
              state_reg <= RUN;
            end
          end
          FLUSH:   state_reg <= RUN;
          default: state_reg <= RUN;
        endcase
      end
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (head_pop) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_unit.sv
// Self-checking bench for retire_unit: directed cases plus randomized ROB traffic vs. a behavioural model.
module tb_retire_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        head_valid = 1'b0;
  logic [31:0] head_val = '0;
  logic [4:0]  head_rd = '0;
  logic        head_store = 1'b0;
  logic [31:0] head_addr = '0;
  logic        head_ex = 1'b0;
  logic [31:0] head_pc = '0;
  logic        head_pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ack = 1'b0;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  retire_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .head_valid(head_valid), .head_val(head_val), .head_rd(head_rd),
    .head_store(head_store), .head_addr(head_addr), .head_ex(head_ex), .head_pc(head_pc),
    .head_pop(head_pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
    .flush(flush), .redirect_pc(redirect_pc), .epc(epc)
`ifdef RETIRE_COUNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    bit          ex;
    bit          store;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] addr;
    logic [31:0] pc;
  } ent_t;

  ent_t rob[$];
  int checks = 0;
  int errors = 0;

  // Model: what the architectural side effects must look like after each edge.
  bit          m_store_busy, m_flush_cycle, m_ack_hold;
  logic        e_rf_we, e_st_req, e_flush;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata, e_st_addr, e_st_data, e_epc;
  int unsigned e_cnt;

  bit want_valid, drv_stall, drv_ack;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_store_busy = 0; m_flush_cycle = 0; m_ack_hold = 0;
    e_rf_we = 0; e_rf_waddr = '0; e_rf_wdata = '0;
    e_st_req = 0; e_st_addr = '0; e_st_data = '0;
    e_flush = 0; e_epc = '0; e_cnt = 0;
  endtask

  task automatic check_regs();
    chk("rf_we", {31'b0, rf_we}, {31'b0, e_rf_we});
    chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, e_rf_waddr});
    chk("rf_wdata", rf_wdata, e_rf_wdata);
    chk("st_req", {31'b0, st_req}, {31'b0, e_st_req});
    chk("st_addr", st_addr, e_st_addr);
    chk("st_data", st_data, e_st_data);
    chk("flush", {31'b0, flush}, {31'b0, e_flush});
    chk("epc", epc, e_epc);
    chk("redirect_pc", redirect_pc, 32'h8000_0180);
`ifdef RETIRE_COUNT_EN
    chk("retired_cnt", retired_cnt, e_cnt);
`endif
  endtask

  // One clock: check last edge's results, drive new inputs, predict pop and next results.
  task automatic cycle();
    ent_t h;
    bit   hv;
    bit   exp_pop;
    @(negedge clk);
    check_regs();
    hv = want_valid && (rob.size() > 0);
    if (hv) begin
      h = rob[0];
    end else begin
      h.ex = 1'($urandom); h.store = 1'($urandom); h.rd = 5'($urandom);
      h.val = $urandom; h.addr = $urandom; h.pc = $urandom;
    end
    head_valid = hv; head_ex = h.ex; head_store = h.store; head_rd = h.rd;
    head_val = h.val; head_addr = h.addr; head_pc = h.pc;
    stall = drv_stall; st_ack = drv_ack;
    #1;
    exp_pop = 0;
    e_rf_we = 0;
    e_flush = 0;
    if (drv_stall) begin
      if (m_store_busy && drv_ack) m_ack_hold = 1;
    end else if (m_flush_cycle) begin
      m_flush_cycle = 0;
    end else if (m_store_busy) begin
      if (drv_ack) begin
        exp_pop = 1; e_st_req = 0; m_store_busy = 0; m_ack_hold = 0;
      end
    end else if (hv) begin
      if (h.ex) begin
        exp_pop = 1; e_flush = 1; e_epc = h.pc; m_flush_cycle = 1;
      end else if (h.store) begin
        e_st_req = 1; e_st_addr = h.addr; e_st_data = h.val; m_store_busy = 1;
      end else begin
        exp_pop = 1; e_rf_we = (h.rd != 5'd0); e_rf_waddr = h.rd; e_rf_wdata = h.val;
      end
    end
    chk("head_pop", {31'b0, head_pop}, {31'b0, exp_pop});
    if (exp_pop) begin
      e_cnt++;
      if (rob.size() > 0) void'(rob.pop_front());
    end
    $display("cyc t=%0t hv=%0b stall=%0b ack=%0b pop=%0b rf_we=%0b st_req=%0b flush=%0b",
             $time, hv, drv_stall, drv_ack, head_pop, rf_we, st_req, flush);
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(bit ex, bit store, logic [4:0] rd, logic [31:0] val,
                              logic [31:0] addr, logic [31:0] pc);
    ent_t e;
    e.ex = ex; e.store = store; e.rd = rd; e.val = val; e.addr = addr; e.pc = pc;
    return e;
  endfunction

  initial begin
    model_reset();
    // Reset state, with a would-be excepting head to show head_pop stays low.
    head_valid = 1; head_ex = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_head_pop", {31'b0, head_pop}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_st_req", {31'b0, st_req}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    head_valid = 0; head_ex = 0;
    @(negedge clk);
    rst_n = 1;
    want_valid = 1; drv_stall = 0; drv_ack = 0;

    // Three back-to-back writes.
    rob.push_back(mk(0, 0, 5'd3, 32'h11, 0, 32'h100));
    rob.push_back(mk(0, 0, 5'd4, 32'h22, 0, 32'h104));
    rob.push_back(mk(0, 0, 5'd5, 32'h33, 0, 32'h108));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("wr_pop", {31'b0, head_pop}, 32'd1);
      post();
      chk("wr_rf_we", {31'b0, rf_we}, 32'd1);
      chk("wr_waddr", {27'b0, rf_waddr}, 32'(3 + i));
      chk("wr_wdata", rf_wdata, 32'(17 * (i + 1)));
    end

    // Store acked in the third request cycle.
    rob.push_back(mk(0, 1, 5'd7, 32'hDEAD, 32'h1000, 32'h10C));
    cycle();
    chk("st_first_pop", {31'b0, head_pop}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drv_ack = (i == 2);
      cycle();
      chk("st_req_held", {31'b0, st_req}, 32'd1);
      chk("st_addr_held", st_addr, 32'h1000);
      chk("st_data_held", st_data, 32'hDEAD);
      chk("st_pop", {31'b0, head_pop}, {31'b0, drv_ack});
    end
    drv_ack = 0;
    post();
    chk("st_req_drop", {31'b0, st_req}, 32'd0);

    // Exception.
    rob.push_back(mk(1, 0, 5'd9, 32'h99, 0, 32'h400));
    cycle();
    chk("ex_pop", {31'b0, head_pop}, 32'd1);
    post();
    chk("ex_flush", {31'b0, flush}, 32'd1);
    chk("ex_redirect", redirect_pc, 32'h8000_0180);
    chk("ex_epc", epc, 32'h400);
    chk("ex_no_rf", {31'b0, rf_we}, 32'd0);
    want_valid = 0;
    cycle();
    post();
    chk("ex_flush_1cyc", {31'b0, flush}, 32'd0);
    want_valid = 1;

    // Write to r0 and an excepting store.
    rob.push_back(mk(0, 0, 5'd0, 32'hFF, 0, 32'h404));
    cycle();
    chk("r0_pop", {31'b0, head_pop}, 32'd1);
    post();
    chk("r0_rf_we", {31'b0, rf_we}, 32'd0);
    rob.push_back(mk(1, 1, 5'd2, 32'h5, 32'h2000, 32'h408));
    cycle();
    post();
    chk("exst_no_req", {31'b0, st_req}, 32'd0);
    cycle();

    // Stall on a valid write, then a store whose ack coincides with stall.
    rob.push_back(mk(0, 0, 5'd6, 32'h66, 0, 32'h40C));
    drv_stall = 1;
    repeat (2) begin
      cycle();
      chk("stall_pop", {31'b0, head_pop}, 32'd0);
    end
    drv_stall = 0;
    cycle();
    chk("unstall_pop", {31'b0, head_pop}, 32'd1);
    rob.push_back(mk(0, 1, 5'd1, 32'hBEEF, 32'h3000, 32'h410));
    cycle();
    drv_stall = 1; drv_ack = 1;
    cycle();
    chk("stall_ack_pop", {31'b0, head_pop}, 32'd0);
    drv_stall = 0;
    cycle();
    chk("late_ack_pop", {31'b0, head_pop}, 32'd1);
    drv_ack = 0;

    // Async reset while waiting on a store.
    rob.push_back(mk(0, 1, 5'd1, 32'h1234, 32'h4000, 32'h414));
    cycle();
    post();
    chk("pre_rst_req", {31'b0, st_req}, 32'd1);
    head_valid = 0; stall = 0; st_ack = 0; want_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_drop_req", {31'b0, st_req}, 32'd0);
    chk("rst_no_pop", {31'b0, head_pop}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    chk("rst_entry_kept", 32'(rob.size()), 32'd1);
    want_valid = 1;
    for (int i = 0; i < 4; i++) rob.push_back(mk(0, 0, 5'(10 + i), 32'(i), 0, 32'h500));
    cycle();
    drv_ack = 1;
    cycle();
    drv_ack = 0;
    repeat (4) cycle();
`ifdef RETIRE_COUNT_EN
    post();
    chk("cnt_after_five", retired_cnt, 32'd5);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (rob.size() < 4) begin
        int unsigned r;
        r = $urandom_range(99);
        rob.push_back(mk(r < 8, (r >= 8 && r < 30) || (r < 8 && 1'($urandom)),
                         ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom),
                         $urandom, $urandom, $urandom));
      end
      want_valid = ($urandom_range(4) != 0);
      drv_stall  = ($urandom_range(5) == 0);
      drv_ack    = m_store_busy && (m_ack_hold || ($urandom_range(2) == 0));
      cycle();
    end
    drv_stall = 0; drv_ack = 0; want_valid = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
Name: retire_unit

Overview:
- In-order commit stage that consumes the reorder buffer head entry and turns it into architectural side effects.
- A committed entry produces one of three things: a register-file write, a data-memory store with a req/ack handshake, or a precise exception.
- An exception captures the EPC, flushes the pipeline and redirects fetch to the exception vector.
- The block pops the buffer head only when the entry's side effect is guaranteed.

Parameters:
- EXC_VECTOR, 32'h8000_0180: fetch redirect address on exception.
- DW, 32: data/address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  global pipeline stall; freezes the FSM and suppresses pops.
- head_valid  in  1  head entry has completed.
- head_val  in  DW  result value, or store data.
- head_rd  in  5  destination register.
- head_store  in  1  entry is a store.
- head_addr  in  DW  store address.
- head_ex  in  1  entry raised an exception.
- head_pc  in  DW  PC of the entry.
- head_pop  out  1  advance buffer head (combinational).
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DW  register-file write data.
- st_req  out  1  store request to data memory (registered, level).
- st_addr  out  DW  store address.
- st_data  out  DW  store data.
- st_ack  in  1  memory accepted the store.
- flush  out  1  one-cycle pipeline and buffer flush pulse.
- redirect_pc  out  DW  fetch target, valid while flush=1; constant EXC_VECTOR.
- epc  out  DW  PC of the last excepting instruction.

Behaviour:
- Reset (async on rst_n low): state=RUN; rf_we=0, rf_waddr=0, rf_wdata=0; st_req=0, st_addr=0, st_data=0; flush=0; epc=0. head_pop is 0 while in reset.
- FSM has three states: RUN, ST_WAIT, FLUSH.
- RUN, no stall, head_valid=1, with priority ex > store > write:
  - head_ex=1: head_pop=1. Next cycle: flush=1, epc=head_pc, state=FLUSH. No rf write or store is issued for this entry.
  - head_store=1: head_pop=0. Next cycle: st_req=1, st_addr=head_addr, st_data=head_val, state=ST_WAIT.
  - Otherwise: head_pop=1. Next cycle: rf_we=(head_rd!=0), rf_waddr=head_rd, rf_wdata=head_val. Back-to-back retirement is one entry per cycle.
- RUN with head_valid=0: head_pop=0; rf_we drops to 0 next cycle.
- ST_WAIT:
  - st_req, st_addr and st_data are held stable until st_ack.
  - On a cycle with st_ack=1 and no stall: head_pop=1; st_req=0 next cycle; state=RUN.
  - If st_ack is asserted in the same cycle as stall, it is ignored and must be held by memory.
- FLUSH: lasts exactly one cycle. flush=1 in this cycle, head_pop=0, then state=RUN. External logic clears the buffer on flush, so head_valid is don't-care here.
- stall=1:
  - head_pop=0 and state is held.
  - rf_we and flush are forced to 0 next cycle.
  - st_req and its payload are held.
- Write latency: register write appears one cycle after the pop. Store: req one cycle after head is seen; pop in the ack cycle.
- Boundaries:
  - An exception on a store entry behaves as an exception; no st_req is issued.
  - A write to r0 pops the entry but keeps rf_we=0.
  - rst_n asserted in ST_WAIT drops st_req immediately; the entry stays unpopped.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined: adds output retired_cnt [31:0], reset 0. It increments by 1 on every head_pop cycle, exceptions included, and wraps at 2^32.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state enum retire_state_t {RUN, ST_WAIT, FLUSH}
  - constant EXC_VECTOR_DEFAULT
  - constant REG_ZERO = 5'd0
  - width localparams shared with the reorder buffer
- No sub-module; single flat module.

Test Plan:
- Three consecutive valid writes, rd=3/4/5 with val=0x11/0x22/0x33 -> head_pop high three consecutive cycles; rf_we high with matching waddr/wdata one cycle later each.
- Store, addr=0x1000, val=0xDEAD, st_ack after 3 cycles -> st_req held for 3 cycles with stable payload; head_pop exactly once, in the ack cycle; st_req=0 the cycle after.
- Exception entry, pc=0x400 -> head_pop=1; next cycle flush=1, redirect_pc=0x80000180, epc=0x400; no rf_we; flush lasts exactly one cycle.
- Write with rd=0, val=0xFF -> head_pop=1, rf_we stays 0.
- stall=1 for 2 cycles with head_valid=1 -> no pop and no rf_we; retire proceeds the cycle stall drops. Repeat during ST_WAIT with st_ack coincident with stall -> ack ignored, pop only on a later unstalled ack.
- rst_n pulsed low mid ST_WAIT -> st_req=0 immediately; state=RUN after release; with RETIRE_COUNT_EN, retired_cnt=0 after reset and counts 5 after five retirements.
